exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM pipeline, directly downstream of the forwarding unit. Each cycle it:
- selects each ALU operand from the ID/EX value, the MEM-stage result or the WB value, using the forwarding unit's per-source select codes;
- builds the second operand (Val2);
- runs the ALU and updates the NZCV status register;
- latches the result and control into the EX/MEM pipeline register.

The registered destination and write-enable are the MEM-stage inputs the forwarding unit compares against.

## Interface
- No parameters. Data width is fixed at 32, register index at 4.
- Clocking: one clock. Reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  memory stall; holds all state
- exe_cmd  in  4  ALU command, encodings in package
- wb_en, mem_r_en, mem_w_en  in  1 each  ID/EX control
- s  in  1  update status register
- imm  in  1  Val2 is a rotated immediate
- shift_operand  in  12  ARM shifter operand field
- signed_imm_24  in  24  branch offset
- pc  in  32  PC+4 of the instruction
- val_rn, val_rm  in  32 each  register-file operands
- dest  in  4  destination register
- sel_src1, sel_src2  in  2 each  forwarding selects:
  - 0 = ID/EX value
  - 1 = mem_fwd_val
  - 2 = wb_fwd_val
  - 3 = treated as 0
- mem_fwd_val  in  32  EX/MEM ALU result
- wb_fwd_val  in  32  writeback value
- branch_addr  out  32  pc + sign-extended signed_imm_24 shifted left by 2, combinational
- status_out  out  4  registered {N,Z,C,V}
- exe_wb_en, exe_mem_r_en, exe_mem_w_en  out  1 each  registered control
- exe_alu_res  out  32  registered ALU result
- exe_val_rm  out  32  registered forwarded Rm (store data)
- exe_dest  out  4  registered destination

## Operation
- Operand selection:
  - op1 = mux(sel_src1: val_rn / mem_fwd_val / wb_fwd_val).
  - rm_f = mux(sel_src2: val_rm / mem_fwd_val / wb_fwd_val).
- Val2 generation, first match wins:
  - imm=1: zero-extend shift_operand[7:0], then rotate right by 2*shift_operand[11:8].
  - mem_r_en or mem_w_en: zero-extend shift_operand[11:0].
  - Otherwise: rm_f shifted by shift_operand[11:7]. Type shift_operand[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 leaves rm_f unchanged (no RRX).
- ALU, with C the registered carry:
  - MOV 0001: Val2
  - MVN 1001: ~Val2
  - ADD 0010: op1+Val2
  - ADC 0011: op1+Val2+C
  - SUB 0100: op1-Val2
  - SBC 0101: op1-Val2-!C
  - AND 0110, ORR 0111, EOR 1000: bitwise
  - Any other code: result 0, flags unchanged.
  - CMP and TST reuse SUB and AND with wb_en=0. LDR and STR reuse ADD.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add/sub: C is bit 32 of the 33-bit sum. Subtraction is computed as op1 + ~Val2 + cin, with cin = 1 for SUB and C for SBC, so C=1 means no borrow.
  - V = operands of equal sign after inversion, result sign differs.
  - Logical and MOV/MVN: C and V keep their old values.
- Status register loads the new NZCV when s=1 and freeze=0.

## Timing
- All registered outputs and status_out are 0 after reset. Reset overrides freeze.
- Latency: one cycle. Inputs sampled at edge k appear on exe_* after edge k.
- freeze=1: EX/MEM register and status register hold their values. Combinational paths continue to evaluate.
- A flag-setting instruction in EX updates status_out at the edge where it enters MEM.
- The ALU carry-in is the pre-edge status C, so back-to-back ADDS;ADC uses the fresh carry.
- Reset asserted mid-stream clears everything at that edge. The instruction in flight is lost.
- Forwarded values are used in the same cycle with no extra latency.

## Structure
- Shared package arm_pkg holds:
  - EXE_CMD constants;
  - shift-type constants (LSL/LSR/ASR/ROR);
  - forwarding select constants (FWD_NONE=0, FWD_MEM=1, FWD_WB=2);
  - status bit indices.
- Sub-modules:
  - alu: combinational, 32-bit ops plus NZCV output.
  - val2_generator: combinational.
- Status register and EX/MEM register live in exe_stage.

## Test plan
- Reset then idle: all exe_* outputs and status_out equal 0, even with freeze=1 during reset.
- ADD with val_rn=5, Val2 from val_rm=7, sel=0,0: after one edge exe_alu_res=12 and exe_dest is latched. With sel_src1=1 and mem_fwd_val=100 the result is 107. With sel_src2=2 and wb_fwd_val=1 the result is 6.
- SUBS 0x80000000-1: result 0x7FFFFFFF, NZCV=0011. CMP 3,3 with s=1: NZCV=0110 and exe_wb_en=0.
- ADDS 0xFFFFFFFF+1 gives Z=1, C=1. A following ADC 0+0 gives 1. A following ANDS with result 0 gives Z=1 with C still 1.
- Val2 rotated immediate: imm=1, shift_operand=0x4FF gives 0xFF000000. ASR by 4 of 0x80000000 gives 0xF8000000. STR with offset 0x0FC gives op1+0xFC, and exe_val_rm carries the forwarded Rm.
- freeze=1 for 3 cycles with changing inputs and s=1: outputs and status_out are stable, then update on the first edge after freeze=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: ALU command encodings, shifter types,
// forwarding select codes, status bit positions and a rotate helper.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  // A 32-bit shift by 32 yields zero, so amount 0 correctly returns x unchanged.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] amt);
    logic [5:0] back;
    back = 6'd32 - {1'b0, amt};
    return (x >> amt) | (x << back);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; returns the result and the NZCV value that the
// status register would load, with unaffected flags passed through.
module alu
  import arm_pkg::*;
(
  input  logic [31:0] op1_i,
  input  logic [31:0] val2_i,
  input  logic [3:0]  cmd_i,
  input  logic [3:0]  status_i,
  output logic [31:0] res_o,
  output logic [3:0]  status_o
);

  logic [32:0] sum;
  logic [31:0] opB;
  logic        cin;
  logic        arith;
  logic        logical;

  always_comb begin
    res_o    = '0;
    status_o = status_i;
    sum      = '0;
    opB      = '0;
    cin      = 1'b0;
    arith    = 1'b0;
    logical  = 1'b0;
    case (cmd_i)
      EXE_MOV: begin res_o = val2_i;          logical = 1'b1; end
      EXE_MVN: begin res_o = ~val2_i;         logical = 1'b1; end
      EXE_AND: begin res_o = op1_i & val2_i;  logical = 1'b1; end
      EXE_ORR: begin res_o = op1_i | val2_i;  logical = 1'b1; end
      EXE_EOR: begin res_o = op1_i ^ val2_i;  logical = 1'b1; end
      EXE_ADD: begin opB = val2_i;  cin = 1'b0;               arith = 1'b1; end
      EXE_ADC: begin opB = val2_i;  cin = status_i[STATUS_C]; arith = 1'b1; end
      EXE_SUB: begin opB = ~val2_i; cin = 1'b1;               arith = 1'b1; end
      EXE_SBC: begin opB = ~val2_i; cin = status_i[STATUS_C]; arith = 1'b1; end
      default: ;
    endcase
    // Subtraction goes through the same adder, so carry means "no borrow".
    if (arith) begin
      sum                = {1'b0, op1_i} + {1'b0, opB} + {32'd0, cin};
      res_o              = sum[31:0];
      status_o[STATUS_C] = sum[32];
      status_o[STATUS_V] = (op1_i[31] == opB[31]) && (sum[31] != op1_i[31]);
    end
    if (arith || logical) begin
      status_o[STATUS_N] = res_o[31];
      status_o[STATUS_Z] = (res_o == 32'd0);
    end
  end

endmodule

// File: rtl/val2_generator.sv
// Builds the ALU second operand from the shifter field: rotated immediate,
// memory offset, or shifted register.
module val2_generator
  import arm_pkg::*;
(
  input  logic        imm_i,
  input  logic        mem_i,
  input  logic [11:0] shift_operand_i,
  input  logic [31:0] rm_i,
  output logic [31:0] val2_o
);

  logic [4:0] shAmt;

  assign shAmt = shift_operand_i[11:7];

  always_comb begin
    val2_o = '0;
    if (imm_i) begin
      val2_o = rotr32({24'd0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});
    end else if (mem_i) begin
      val2_o = {20'd0, shift_operand_i};
    end else begin
      // Amount 0 falls through each case as an identity; there is no RRX form.
      case (shift_operand_i[6:5])
        SHIFT_LSL: val2_o = rm_i << shAmt;
        SHIFT_LSR: val2_o = rm_i >> shAmt;
        SHIFT_ASR: val2_o = $unsigned($signed(rm_i) >>> shAmt);
        default:   val2_o = rotr32(rm_i, shAmt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, Val2 generation, ALU, NZCV status register
// and the EX/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [3:0]  exe_cmd,
  input  logic        wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        s,
  input  logic        imm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [31:0] pc,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  output logic [31:0] branch_addr,
  output logic [3:0]  status_out,
  output logic        exe_wb_en,
  output logic        exe_mem_r_en,
  output logic        exe_mem_w_en,
  output logic [31:0] exe_alu_res,
  output logic [31:0] exe_val_rm,
  output logic [3:0]  exe_dest
);

  logic [31:0] op1, rmFwd, val2, aluRes;
  logic [3:0]  aluStatus;
  logic [3:0]  status_q, status_d;
  logic        wbEn_q, memREn_q, memWEn_q;
  logic [31:0] aluRes_q, valRm_q;
  logic [3:0]  dest_q;

  // Select code 3 is unused by the forwarding unit and behaves like FWD_NONE.
  function automatic logic [31:0] fwdMux(input logic [1:0] sel, input logic [31:0] idVal,
                                         input logic [31:0] memVal, input logic [31:0] wbVal);
    case (sel)
      FWD_MEM: return memVal;
      FWD_WB:  return wbVal;
      default: return idVal;
    endcase
  endfunction

  assign op1         = fwdMux(sel_src1, val_rn, mem_fwd_val, wb_fwd_val);
  assign rmFwd       = fwdMux(sel_src2, val_rm, mem_fwd_val, wb_fwd_val);
  assign branch_addr = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  val2_generator u_val2 (
    .imm_i           (imm),
    .mem_i           (mem_r_en | mem_w_en),
    .shift_operand_i (shift_operand),
    .rm_i            (rmFwd),
    .val2_o          (val2)
  );

  alu u_alu (
    .op1_i    (op1),
    .val2_i   (val2),
    .cmd_i    (exe_cmd),
    .status_i (status_q),
    .res_o    (aluRes),
    .status_o (aluStatus)
  );

  assign status_d = (s && !freeze) ? aluStatus : status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      wbEn_q   <= 1'b0;
      memREn_q <= 1'b0;
      memWEn_q <= 1'b0;
      aluRes_q <= '0;
      valRm_q  <= '0;
      dest_q   <= '0;
    end else begin
      status_q <= status_d;
      if (!freeze) begin
        wbEn_q   <= wb_en;
        memREn_q <= mem_r_en;
        memWEn_q <= mem_w_en;
        aluRes_q <= aluRes;
        valRm_q  <= rmFwd;
        dest_q   <= dest;
      end
    end
  end

  assign status_out   = status_q;
  assign exe_wb_en    = wbEn_q;
  assign exe_mem_r_en = memREn_q;
  assign exe_mem_w_en = memWEn_q;
  assign exe_alu_res  = aluRes_q;
  assign exe_val_rm   = valRm_q;
  assign exe_dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_exe_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, wb_en, mem_r_en, mem_w_en, s, imm;
  logic [3:0]  exe_cmd, dest;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc, val_rn, val_rm, mem_fwd_val, wb_fwd_val;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] branch_addr, exe_alu_res, exe_val_rm;
  logic [3:0]  status_out, exe_dest;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .s(s), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .dest(dest),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_addr(branch_addr), .status_out(status_out),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_alu_res(exe_alu_res), .exe_val_rm(exe_val_rm), .exe_dest(exe_dest)
  );

  task automatic applyStimulus(input logic [3:0] cmd, input logic sIn, input logic immIn,
                               input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                               input logic [1:0] s1, input logic [1:0] s2, input logic wb,
                               input logic mr, input logic mw, input logic [3:0] dst);
    exe_cmd = cmd; s = sIn; imm = immIn; shift_operand = so;
    val_rn = rn; val_rm = rm; sel_src1 = s1; sel_src2 = s2;
    wb_en = wb; mem_r_en = mr; mem_w_en = mw; dest = dst;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_res"},    exe_alu_res, 32'd0);
    checkOutput({tag, "_status"}, {28'd0, status_out}, 32'd0);
    checkOutput({tag, "_wb"},     {31'd0, exe_wb_en}, 32'd0);
    checkOutput({tag, "_memr"},   {31'd0, exe_mem_r_en}, 32'd0);
    checkOutput({tag, "_memw"},   {31'd0, exe_mem_w_en}, 32'd0);
    checkOutput({tag, "_valrm"},  exe_val_rm, 32'd0);
    checkOutput({tag, "_dest"},   {28'd0, exe_dest}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b1;
    pc = 32'h100; signed_imm_24 = 24'd0; mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
    applyStimulus(EXE_ADD, 1'b1, 1'b0, 12'h000, 32'd5, 32'd7, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd3);
    tick(); tick();
    checkCleared("reset");

    rst = 1'b0; freeze = 1'b0;
    applyStimulus(EXE_ADD, 1'b0, 1'b0, 12'h000, 32'd5, 32'd7, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick();
    checkOutput("add_res", exe_alu_res, 32'd12);
    checkOutput("add_dest", {28'd0, exe_dest}, 32'd3);
    checkOutput("add_wb", {31'd0, exe_wb_en}, 32'd1);

    mem_fwd_val = 32'd100; sel_src1 = FWD_MEM;
    tick();
    checkOutput("fwd_mem_op1", exe_alu_res, 32'd107);

    wb_fwd_val = 32'd1; sel_src1 = FWD_NONE; sel_src2 = FWD_WB;
    tick();
    checkOutput("fwd_wb_rm", exe_alu_res, 32'd6);

    sel_src1 = 2'd3; sel_src2 = 2'd3;
    tick();
    checkOutput("fwd_sel3", exe_alu_res, 32'd12);

    applyStimulus(EXE_SUB, 1'b1, 1'b0, 12'h000, 32'd3, 32'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("cmp_status", {28'd0, status_out}, 32'h6);
    checkOutput("cmp_wb", {31'd0, exe_wb_en}, 32'd0);

    applyStimulus(EXE_SUB, 1'b1, 1'b0, 12'h000, 32'h8000_0000, 32'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick();
    checkOutput("subs_res", exe_alu_res, 32'h7FFF_FFFF);
    checkOutput("subs_status", {28'd0, status_out}, 32'h3);

    applyStimulus(EXE_ADD, 1'b1, 1'b0, 12'h000, 32'd1, 32'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick();
    checkOutput("adds_small_status", {28'd0, status_out}, 32'h0);

    applyStimulus(EXE_ADD, 1'b1, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick();
    checkOutput("adds_wrap_res", exe_alu_res, 32'd0);
    checkOutput("adds_wrap_status", {28'd0, status_out}, 32'h6);

    applyStimulus(EXE_ADC, 1'b0, 1'b0, 12'h000, 32'd0, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("adc_carry_res", exe_alu_res, 32'd1);

    applyStimulus(EXE_AND, 1'b1, 1'b0, 12'h000, 32'hF0, 32'h0F, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("ands_res", exe_alu_res, 32'd0);
    checkOutput("ands_status", {28'd0, status_out}, 32'h6);

    applyStimulus(EXE_ORR, 1'b1, 1'b0, 12'h000, 32'h8000_0000, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("orrs_res", exe_alu_res, 32'h8000_0000);
    checkOutput("orrs_status", {28'd0, status_out}, 32'hA);

    applyStimulus(4'b0000, 1'b1, 1'b0, 12'h000, 32'd5, 32'd7, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("badcmd_res", exe_alu_res, 32'd0);
    checkOutput("badcmd_status", {28'd0, status_out}, 32'hA);

    applyStimulus(EXE_MVN, 1'b0, 1'b0, 12'h000, 32'd5, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("mvn_res", exe_alu_res, 32'hFFFF_FFFF);

    applyStimulus(EXE_MOV, 1'b0, 1'b1, 12'h4FF, 32'd0, 32'h1234, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("imm_rot", exe_alu_res, 32'hFF00_0000);

    applyStimulus(EXE_MOV, 1'b0, 1'b0, 12'h240, 32'd0, 32'h8000_0000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("asr4", exe_alu_res, 32'hF800_0000);

    shift_operand = 12'h220;
    tick();
    checkOutput("lsr4", exe_alu_res, 32'h0800_0000);

    applyStimulus(EXE_MOV, 1'b0, 1'b0, 12'h100, 32'd0, 32'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("lsl2", exe_alu_res, 32'd12);

    applyStimulus(EXE_MOV, 1'b0, 1'b0, 12'h460, 32'd0, 32'hAB, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("ror8", exe_alu_res, 32'hAB00_0000);

    mem_fwd_val = 32'hDEAD;
    applyStimulus(EXE_ADD, 1'b0, 1'b0, 12'h0FC, 32'h1000, 32'h1111, 2'd0, FWD_MEM, 1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    checkOutput("str_addr", exe_alu_res, 32'h10FC);
    checkOutput("str_data", exe_val_rm, 32'hDEAD);
    checkOutput("str_memw", {31'd0, exe_mem_w_en}, 32'd1);

    applyStimulus(EXE_ADD, 1'b0, 1'b0, 12'h010, 32'h2000, 32'h1111, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd6);
    tick();
    checkOutput("ldr_addr", exe_alu_res, 32'h2010);
    checkOutput("ldr_memr", {31'd0, exe_mem_r_en}, 32'd1);

    pc = 32'h100; signed_imm_24 = 24'hFF_FFFF;
    #1;
    checkOutput("branch_neg", branch_addr, 32'h0000_00FC);
    signed_imm_24 = 24'd2;
    #1;
    checkOutput("branch_pos", branch_addr, 32'h0000_0108);

    applyStimulus(EXE_ADD, 1'b1, 1'b0, 12'h000, 32'd1, 32'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick();
    checkOutput("prefreeze_res", exe_alu_res, 32'd2);
    checkOutput("prefreeze_status", {28'd0, status_out}, 32'h0);

    freeze = 1'b1;
    applyStimulus(EXE_SUB, 1'b1, 1'b0, 12'h000, 32'd0, 32'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      val_rn = (i == 1) ? 32'd5 : 32'd0;
      tick();
      checkOutput("freeze_res", exe_alu_res, 32'd2);
      checkOutput("freeze_status", {28'd0, status_out}, 32'h0);
      checkOutput("freeze_dest", {28'd0, exe_dest}, 32'd4);
    end
    freeze = 1'b0;
    tick();
    checkOutput("unfreeze_res", exe_alu_res, 32'hFFFF_FFFF);
    checkOutput("unfreeze_status", {28'd0, status_out}, 32'h8);
    checkOutput("unfreeze_dest", {28'd0, exe_dest}, 32'd9);

    applyStimulus(EXE_SBC, 1'b0, 1'b0, 12'h000, 32'd5, 32'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd7);
    tick();
    checkOutput("sbc_borrow", exe_alu_res, 32'd1);

    applyStimulus(EXE_ADD, 1'b1, 1'b0, 12'h000, 32'd9, 32'd9, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd8);
    rst = 1'b1;
    tick();
    checkCleared("midreset");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
